// File: rtl/rt_cdc_tx_fifo.sv
// rtl/rt_cdc_tx_fifo.sv - A-domain FIFO feeding a data-enable clock-crossing stage
module rt_cdc_tx_fifo #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              rt_i_aclk,
    input  logic              rt_i_rstn_aclk,
    input  logic              rt_i_flush_aclk,
    input  logic              rt_i_valid_aclk,
    input  logic [DWIDTH-1:0] rt_i_data_aclk,
    output logic              rt_o_ready_aclk,
    output logic [AWIDTH:0]   rt_o_level_aclk,
    output logic              rt_o_de_aclk,
    output logic [DWIDTH-1:0] rt_o_din_aclk,
    input  logic              rt_i_busy_aclk,
    output logic              rt_o_idle_aclk
);

    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    logic [AWIDTH:0]   r_wr_ptr;
    logic [AWIDTH:0]   r_rd_ptr;
    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic              r_de;
    logic [DWIDTH-1:0] r_din;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [AWIDTH:0]   w_level;
    logic [DWIDTH-1:0] w_head;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign w_full  = (r_wr_ptr[AWIDTH] != r_rd_ptr[AWIDTH]) &&
                     (r_wr_ptr[AWIDTH-1:0] == r_rd_ptr[AWIDTH-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_head  = r_mem[r_rd_ptr[AWIDTH-1:0]];

    // Flush blocks both sides: no accept and no pop on the clearing edge.
    assign w_push  = rt_i_valid_aclk & rt_o_ready_aclk;
    assign w_pop   = (r_state == S_IDLE) & ~w_empty & ~rt_i_busy_aclk & ~rt_i_flush_aclk;

    assign rt_o_ready_aclk = ~w_full & ~rt_i_flush_aclk;
    assign rt_o_level_aclk = w_level;
    assign rt_o_de_aclk    = r_de;
    assign rt_o_din_aclk   = r_din;
    assign rt_o_idle_aclk  = (w_level == '0) & (r_state == S_IDLE) & ~rt_i_busy_aclk;

    // Storage array: written on accepted pushes, no reset needed.
    always_ff @(posedge rt_i_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AWIDTH-1:0]] <= rt_i_data_aclk;
        end
    end

    // Write/read pointers; flush clears both regardless of push/pop requests.
    always_ff @(posedge rt_i_aclk or negedge rt_i_rstn_aclk) begin
        if (!rt_i_rstn_aclk) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (rt_i_flush_aclk) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Strobe sequencer: one de pulse, then wait for the crossing to go idle.
    always_ff @(posedge rt_i_aclk or negedge rt_i_rstn_aclk) begin
        if (!rt_i_rstn_aclk) begin
            r_state <= S_IDLE;
            r_de    <= 1'b0;
            r_din   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_de    <= 1'b1;
                        r_din   <= w_head;
                        r_state <= S_SEND;
                    end else begin
                        r_de    <= 1'b0;
                    end
                end
                S_SEND: begin
                    // Crossing raises busy the cycle after it sees de.
                    r_de    <= 1'b0;
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    r_de <= 1'b0;
                    if (!rt_i_busy_aclk) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_de    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rt_cdc_tx_fifo.sv
// tb/tb_rt_cdc_tx_fifo.sv - randomized model-checked bench for rt_cdc_tx_fifo
module tb_rt_cdc_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       busy  = 1'b0;
    logic       ready;
    logic [4:0] level;
    logic       de;
    logic [7:0] din;
    logic       idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rt_cdc_tx_fifo #(.DWIDTH(8), .AWIDTH(4)) dut (
        .rt_i_aclk       (clk),
        .rt_i_rstn_aclk  (rst_n),
        .rt_i_flush_aclk (flush),
        .rt_i_valid_aclk (valid),
        .rt_i_data_aclk  (data),
        .rt_o_ready_aclk (ready),
        .rt_o_level_aclk (level),
        .rt_o_de_aclk    (de),
        .rt_o_din_aclk   (din),
        .rt_i_busy_aclk  (busy),
        .rt_o_idle_aclk  (idle)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of stored words plus a strobe permission flag.
    // After a strobe, permission returns once busy has been seen low at an
    // edge at least two edges after the strobe edge.
    byte unsigned m_q[$];
    bit           m_de        = 1'b0;
    bit [7:0]     m_din       = 8'h00;
    bit           m_armed     = 1'b1;
    int           m_since     = 99;
    bit           m_busy_edge = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit do_push;
        bit do_strobe;
        if (!rst_n) begin
            m_q.delete();
            m_de        = 1'b0;
            m_din       = 8'h00;
            m_armed     = 1'b1;
            m_since     = 99;
            m_busy_edge = 1'b0;
        end else begin
            do_push   = valid && (m_q.size() < DEPTH) && !flush;
            if (m_since < 99) m_since++;
            do_strobe = m_armed && (m_q.size() > 0) && !busy && !flush;
            if (!m_armed && m_since >= 2 && !busy) m_armed = 1'b1;
            m_busy_edge = busy;
            m_de        = do_strobe;
            if (do_strobe) begin
                m_din   = m_q.pop_front();
                m_armed = 1'b0;
                m_since = 0;
            end
            if (flush) m_q.delete();
            if (do_push) m_q.push_back(data);
        end
    end

    // Per-cycle comparison of every output against the model.
    byte unsigned dut_out[$];
    bit           prev_de   = 1'b0;
    int           max_level = 0;

    always @(negedge clk) begin
        check("ready", ready, (m_q.size() < DEPTH) && !flush);
        check("level", level, m_q.size());
        check("idle", idle, (m_q.size() == 0) && m_armed && !busy);
        check("de", de, m_de);
        check("din", din, m_din);
        if (de === 1'b1) begin
            check("de_consecutive", prev_de, 0);
            check("de_while_busy", m_busy_edge, 0);
            dut_out.push_back(din);
        end
        if (int'(level) > max_level) max_level = level;
        prev_de = de;
    end

    // Crossing model: busy for busy_len cycles starting the cycle after de.
    int busy_len   = 0;
    bit force_busy = 1'b0;
    int stray_pct  = 0;
    int cross_cnt  = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (cross_cnt > 0) begin
            busy = 1'b1;
            cross_cnt--;
        end else begin
            busy = force_busy || ($urandom_range(99) < stray_pct);
        end
        if (de === 1'b1) cross_cnt = busy_len;
    end

    byte unsigned sent[$];

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Present a word and hold it until accepted; valid stays high afterwards.
    task automatic push_word(input logic [7:0] d);
        bit r;
        int n;
        valid = 1'b1;
        data  = d;
        n     = 0;
        do begin
            @(negedge clk);
            r = ready;
            cyc();
            n++;
        end while (!r && n < 500);
        if (r) sent.push_back(d);
        else check("push_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!((m_q.size() == 0) && m_armed && !busy && cross_cnt == 0) && n < 1000) begin
            cyc();
            n++;
        end
        if (n >= 1000) check("drain_timeout", 0, 1);
        repeat (3) cyc();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_de", de, 0);
        check("rst_level", level, 0);
        check("rst_ready", ready, 1);
        check("rst_idle", idle, 1);
        rst_n = 1'b1;

        // T1 single word, busy tied low
        cyc();
        valid = 1'b1;
        data  = 8'hA5;
        cyc();
        valid = 1'b0;
        check("t1_de_early", de, 0);
        cyc();
        check("t1_de", de, 1);
        check("t1_din", din, 8'hA5);
        cyc();
        check("t1_de_one_cycle", de, 0);
        repeat (3) cyc();
        check("t1_level", level, 0);
        check("t1_idle", idle, 1);

        // T2 burst of 20 against a slow crossing
        dut_out.delete();
        sent.delete();
        max_level = 0;
        busy_len  = 6;
        for (int i = 0; i < 20; i++) push_word(8'(i));
        valid = 1'b0;
        wait_drain();
        check("t2_full_seen", max_level, 16);
        check("t2_count", dut_out.size(), 20);
        for (int i = 0; i < 20 && i < dut_out.size(); i++) check("t2_order", dut_out[i], i);

        // T3 random stream with stray busy
        dut_out.delete();
        sent.delete();
        max_level = 0;
        stray_pct = 15;
        for (int i = 0; i < 100; i++) begin
            busy_len = $urandom_range(0, 5);
            valid    = 1'b0;
            repeat ($urandom_range(0, 3)) cyc();
            push_word(8'($urandom));
        end
        valid     = 1'b0;
        stray_pct = 0;
        wait_drain();
        check("t3_count", dut_out.size(), 100);
        for (int i = 0; i < 100 && i < dut_out.size(); i++) check("t3_order", dut_out[i], sent[i]);
        check("t3_level_bound", max_level <= 16, 1);

        // T4 flush during S_HOLD
        dut_out.delete();
        busy_len   = 6;
        force_busy = 1'b1;
        cyc();
        for (int i = 1; i <= 5; i++) push_word(8'(i));
        valid      = 1'b0;
        force_busy = 1'b0;
        for (int n = 0; n < 20 && de !== 1'b1; n++) cyc();
        check("t4_strobe", de, 1);
        check("t4_din", din, 8'h01);
        cyc();
        flush = 1'b1;
        valid = 1'b1;
        data  = 8'h77;
        cyc();
        flush = 1'b0;
        valid = 1'b0;
        check("t4_level", level, 0);
        wait_drain();
        repeat (10) cyc();
        check("t4_strobes", dut_out.size(), 1);
        check("t4_din_kept", din, 8'h01);

        // T5 push and pop on the same edge at level 3
        dut_out.delete();
        busy_len   = 2;
        force_busy = 1'b1;
        repeat (2) cyc();
        push_word(8'h30);
        push_word(8'h31);
        force_busy = 1'b0;
        push_word(8'h32);
        push_word(8'h33);
        valid = 1'b0;
        check("t5_level", level, 3);
        check("t5_de", de, 1);
        check("t5_din", din, 8'h30);
        wait_drain();
        check("t5_count", dut_out.size(), 4);
        for (int i = 0; i < 4 && i < dut_out.size(); i++) check("t5_order", dut_out[i], 8'h30 + i);

        // T6 asynchronous reset during S_SEND
        busy_len = 0;
        push_word(8'h5A);
        push_word(8'h5B);
        valid = 1'b0;
        for (int n = 0; n < 20 && de !== 1'b1; n++) cyc();
        check("t6_de_before", de, 1);
        check("t6_level_before", level, 1);
        rst_n = 1'b0;
        #1;
        check("t6_de", de, 0);
        check("t6_level", level, 0);
        check("t6_ready", ready, 1);
        check("t6_din", din, 0);
        cyc();
        rst_n = 1'b1;
        repeat (5) cyc();
        check("t6_idle_after", idle, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
